// File: rtl/mem_ctrl_if.sv
// Signal bundle between mem_ctrl, its requesters (LSB, fetch unit) and the byte-wide RAM.
interface mem_ctrl_if;
  logic        rdy;
  logic        flush;
  logic [31:0] lsb_oprand;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_wdata;
  logic [1:0]  ready;
  logic [31:0] mem_data;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  modport master (
    output rdy, flush, lsb_oprand, lsb_addr, lsb_wdata, if_req, if_addr, mem_din, io_buffer_full,
    input  ready, mem_data, if_done, if_data, mem_dout, mem_a, mem_wr
  );

  modport slave (
    input  rdy, flush, lsb_oprand, lsb_addr, lsb_wdata, if_req, if_addr, mem_din, io_buffer_full,
    output ready, mem_data, if_done, if_data, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: splits LSB loads/stores and instruction fetches into
// 1/2/4 sequential byte accesses on a single-port byte-wide RAM.
module mem_ctrl #(
  parameter logic [1:0] IO_MASK = 2'b11
) (
  input  logic      clk,
  input  logic      rst,
  mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE, S_FETCH} state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_k, w_k_nxt;
  logic [31:0] r_base;
  logic [31:0] r_wdata;
  logic [2:0]  r_funct3;
  logic [23:0] r_buf;
  logic        r_held;
  logic [7:0]  r_din_hold;
  logic        r_load_done;
  logic        r_if_done;
  logic [31:0] r_mem_data;
  logic [31:0] r_if_data;

  logic [2:0]  w_n;
  logic        w_io_stall;
  logic        w_wr_ok;
  logic        w_accept;
  logic        w_finish;
  logic        w_capture;
  logic [7:0]  w_din;
  logic [7:0]  w_dout;
  logic [31:0] w_word;
  logic [31:0] w_ext;
  logic        w_unused;

  assign w_unused = ^{bus.lsb_oprand[31:21], bus.lsb_oprand[19:15],
                      bus.lsb_oprand[11:6], bus.lsb_oprand[4:0]};

  always_comb begin
    case (r_funct3[1:0])
      2'b00:   w_n = 3'd1;
      2'b01:   w_n = 3'd2;
      default: w_n = 3'd4;
    endcase
  end

  assign w_io_stall = (r_base[17:16] == IO_MASK) && bus.io_buffer_full;
  assign w_wr_ok    = (r_state == S_STORE) && !w_io_stall;

  // While frozen the RAM keeps answering for the held address, so the byte that was
  // in flight when rdy dropped is kept aside and used on the first active edge.
  assign w_din = r_held ? r_din_hold : bus.mem_din;

  always_comb begin
    w_dout = '0;
    if (r_state == S_STORE) begin
      case (r_k[1:0])
        2'd0:    w_dout = r_wdata[7:0];
        2'd1:    w_dout = r_wdata[15:8];
        2'd2:    w_dout = r_wdata[23:16];
        default: w_dout = r_wdata[31:24];
      endcase
    end
  end

  assign bus.mem_wr   = bus.rdy && !rst && w_wr_ok;
  assign bus.mem_a    = (r_state == S_IDLE) ? 32'd0 : r_base + {29'd0, r_k};
  assign bus.mem_dout = w_dout;
  assign bus.ready    = {r_load_done, r_state == S_IDLE};
  assign bus.mem_data = r_mem_data;
  assign bus.if_done  = r_if_done;
  assign bus.if_data  = r_if_data;

  // The last byte is taken straight from the RAM bus on the finishing edge.
  always_comb begin
    w_word = {8'h00, r_buf};
    case (r_k)
      3'd1:    w_word[7:0]   = w_din;
      3'd2:    w_word[15:8]  = w_din;
      default: w_word[31:24] = w_din;
    endcase
    case (r_funct3)
      F3_B:    w_ext = {{24{w_word[7]}}, w_word[7:0]};
      F3_BU:   w_ext = {24'd0, w_word[7:0]};
      F3_H:    w_ext = {{16{w_word[15]}}, w_word[15:0]};
      F3_HU:   w_ext = {16'd0, w_word[15:0]};
      default: w_ext = w_word;
    endcase
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!bus.flush && (bus.lsb_oprand[20] || bus.if_req)) begin
          w_accept = 1'b1;
          w_k_nxt  = 3'd0;
          if (bus.lsb_oprand[20]) w_state_nxt = bus.lsb_oprand[5] ? S_STORE : S_LOAD;
          else                    w_state_nxt = S_FETCH;
        end
      end
      S_LOAD, S_FETCH: begin
        if (bus.flush) begin
          w_state_nxt = S_IDLE;
          w_k_nxt     = 3'd0;
        end else if (r_k == w_n) begin
          w_finish    = 1'b1;
          w_state_nxt = S_IDLE;
          w_k_nxt     = 3'd0;
        end else begin
          w_capture = (r_k != 3'd0);
          w_k_nxt   = r_k + 3'd1;
        end
      end
      S_STORE: begin
        if (w_wr_ok) begin
          if (r_k == w_n - 3'd1) begin
            w_state_nxt = S_IDLE;
            w_k_nxt     = 3'd0;
          end else begin
            w_k_nxt = r_k + 3'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_state     <= S_IDLE;
      r_k         <= 3'd0;
      r_base      <= '0;
      r_wdata     <= '0;
      r_funct3    <= '0;
      r_buf       <= '0;
      r_held      <= 1'b0;
      r_din_hold  <= '0;
      r_load_done <= 1'b0;
      r_if_done   <= 1'b0;
      r_mem_data  <= '0;
      r_if_data   <= '0;
    end else if (!bus.rdy) begin
      if (!r_held) r_din_hold <= bus.mem_din;
      r_held <= 1'b1;
    end else begin
      r_held      <= 1'b0;
      r_state     <= w_state_nxt;
      r_k         <= w_k_nxt;
      r_load_done <= 1'b0;
      r_if_done   <= 1'b0;
      if (w_accept) begin
        if (bus.lsb_oprand[20]) begin
          r_base   <= bus.lsb_addr;
          r_funct3 <= bus.lsb_oprand[14:12];
          r_wdata  <= bus.lsb_wdata;
        end else begin
          r_base   <= bus.if_addr;
          r_funct3 <= F3_W;
        end
      end
      if (w_capture) begin
        case (r_k)
          3'd1:    r_buf[7:0]   <= w_din;
          3'd2:    r_buf[15:8]  <= w_din;
          default: r_buf[23:16] <= w_din;
        endcase
      end
      if (w_finish) begin
        if (r_state == S_LOAD) begin
          r_mem_data  <= w_ext;
          r_load_done <= 1'b1;
        end else begin
          r_if_data <= w_word;
          r_if_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: directed scenarios plus randomized loads, stores and fetches
// checked against a byte-array model of memory.
module tb_mem_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_ctrl_if bus();
  mem_ctrl #(.IO_MASK(2'b11)) u_dut (.clk(clk), .rst(rst), .bus(bus.slave));

  localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

  typedef struct packed { logic [31:0] a; logic [7:0] d; } wr_t;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  ram [logic [31:0]];
  logic [7:0]  mdl [logic [31:0]];
  logic [31:0] exp_load_q[$];
  logic [31:0] exp_fetch_q[$];
  wr_t         exp_wr_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
  endtask

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5a;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] mdl_rd(input logic [31:0] a);
    return mdl.exists(a) ? mdl[a] : init_byte(a);
  endfunction

  function automatic void preload(input logic [31:0] a, input logic [7:0] d);
    ram[a] = d;
    mdl[a] = d;
  endfunction

  function automatic int n_of(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  // Reference load: gather little-endian bytes, then extend by width/signedness.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < n_of(f3); i++) v = v | (32'(mdl_rd(a + 32'(i))) << (8 * i));
    if (f3 == B && v[7])  v = v | 32'hFFFF_FF00;
    if (f3 == H && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  function automatic void model_store(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] wd);
    for (int i = 0; i < n_of(f3); i++) begin
      wr_t w;
      w.a = a + 32'(i);
      w.d = wd[8*i +: 8];
      exp_wr_q.push_back(w);
      mdl[w.a] = w.d;
    end
  endfunction

  // Behavioural RAM: one-cycle read latency, write on the clock edge.
  always @(posedge clk) begin
    logic [7:0] rd;
    rd = ram_rd(bus.mem_a);
    if (bus.mem_wr) ram[bus.mem_a] = bus.mem_dout;
    bus.mem_din <= rd;
  end

  // Monitor: pops the scoreboard whenever the DUT presents a result or a write.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ready[1]) begin
        check("ready1 only when idle", {31'd0, bus.ready[0]}, 32'd1);
        if (exp_load_q.size() == 0) check("spurious ready1", {31'd0, bus.ready[1]}, 32'd0);
        else check("load data", bus.mem_data, exp_load_q.pop_front());
      end
      if (bus.if_done) begin
        if (exp_fetch_q.size() == 0) check("spurious if_done", {31'd0, bus.if_done}, 32'd0);
        else check("fetch data", bus.if_data, exp_fetch_q.pop_front());
      end
      if (bus.mem_wr) begin
        if (exp_wr_q.size() == 0) check("spurious mem_wr", {31'd0, bus.mem_wr}, 32'd0);
        else begin
          wr_t w;
          w = exp_wr_q.pop_front();
          check("write addr", bus.mem_a, w.a);
          check("write data", {24'd0, bus.mem_dout}, {24'd0, w.d});
        end
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (!bus.ready[0] && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("idle timeout", {31'd0, bus.ready[0]}, 32'd1);
  endtask

  // Counts edges after the acceptance edge until the pulse is seen.
  task automatic wait_pulse(input bit fetch, output int c);
    c = 0;
    forever begin
      @(negedge clk);
      if (fetch ? bus.if_done : bus.ready[1]) break;
      c++;
      if (c > 100) begin
        check(fetch ? "if_done timeout" : "ready1 timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic issue_lsb(input bit st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input bit expect_result);
    wait_idle();
    bus.lsb_oprand = 32'h0010_0000 | (32'(st) << 5) | (32'(f3) << 12);
    bus.lsb_addr   = a;
    bus.lsb_wdata  = wd;
    if (st) model_store(f3, a, wd);
    else if (expect_result) exp_load_q.push_back(model_load(f3, a));
    @(posedge clk);
    #1;
    bus.lsb_oprand = 32'd0;
  endtask

  task automatic store_run(input bit noise);
    int t = 0;
    forever begin
      if (noise) bus.io_buffer_full = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      if (bus.ready[0]) break;
      @(posedge clk);
      #1;
      t++;
      if (t > 200) begin
        check("store timeout", {31'd0, bus.ready[0]}, 32'd1);
        break;
      end
    end
    bus.io_buffer_full = 1'b0;
  endtask

  task automatic load_and_time(input logic [2:0] f3, input logic [31:0] a, input string name);
    int c;
    issue_lsb(1'b0, f3, a, 32'd0, 1'b1);
    wait_pulse(1'b0, c);
    check(name, c, n_of(f3) + 1);
  endtask

  task automatic fetch_and_time(input logic [31:0] a);
    int c;
    wait_idle();
    bus.if_req  = 1'b1;
    bus.if_addr = a;
    exp_fetch_q.push_back(model_load(W, a));
    @(posedge clk);
    #1;
    bus.if_req = 1'b0;
    wait_pulse(1'b1, c);
    check("fetch latency", c, 5);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    bus.rdy = 1'b1; bus.flush = 1'b0; bus.lsb_oprand = '0; bus.lsb_addr = '0;
    bus.lsb_wdata = '0; bus.if_req = 1'b0; bus.if_addr = '0; bus.io_buffer_full = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset ready",    {30'd0, bus.ready}, 32'd1);
    check("reset mem_a",    bus.mem_a, 32'd0);
    check("reset mem_wr",   {31'd0, bus.mem_wr}, 32'd0);
    check("reset mem_dout", {24'd0, bus.mem_dout}, 32'd0);
    check("reset mem_data", bus.mem_data, 32'd0);
    check("reset if_done",  {31'd0, bus.if_done}, 32'd0);
    check("reset if_data",  bus.if_data, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // LW 0x100: four consecutive addresses, result six cycles after acceptance.
    preload(32'h100, 8'h11); preload(32'h101, 8'h22);
    preload(32'h102, 8'h33); preload(32'h103, 8'h44);
    issue_lsb(1'b0, W, 32'h100, 32'd0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("LW mem_a", bus.mem_a, 32'h100 + 32'(k));
      check("LW mem_wr", {31'd0, bus.mem_wr}, 32'd0);
    end
    @(negedge clk); check("LW ready1 early", {31'd0, bus.ready[1]}, 32'd0);
    @(negedge clk); check("LW ready1 timing", {31'd0, bus.ready[1]}, 32'd1);
    check("LW literal", bus.mem_data, 32'h4433_2211);

    preload(32'h10, 8'h80);
    preload(32'h20, 8'h01); preload(32'h21, 8'h80);
    load_and_time(B,  32'h10, "LB latency");
    load_and_time(BU, 32'h10, "LBU latency");
    load_and_time(H,  32'h20, "LH latency");
    load_and_time(HU, 32'h20, "LHU latency");

    // SH 0xABCD to 0x200: two writes, idle again the cycle after.
    issue_lsb(1'b1, H, 32'h200, 32'h0000_ABCD, 1'b0);
    @(negedge clk); check("SH write1", {31'd0, bus.mem_wr}, 32'd1);
    @(negedge clk); check("SH busy", {31'd0, bus.ready[0]}, 32'd0);
    @(negedge clk); check("SH idle", {30'd0, bus.ready}, 32'd1);

    // SB into the I/O region with the buffer full for three cycles.
    bus.io_buffer_full = 1'b1;
    issue_lsb(1'b1, B, 32'h0003_0000, 32'h0000_005A, 1'b0);
    repeat (3) begin
      @(negedge clk); check("IO stall mem_wr", {31'd0, bus.mem_wr}, 32'd0);
    end
    @(posedge clk); #1 bus.io_buffer_full = 1'b0;
    @(negedge clk); check("IO write", {31'd0, bus.mem_wr}, 32'd1);
    @(negedge clk); check("IO idle", {31'd0, bus.ready[0]}, 32'd1);

    // Simultaneous load and fetch: load first, fetch right after.
    wait_idle();
    bus.lsb_oprand = 32'h0010_0000 | (32'(W) << 12);
    bus.lsb_addr   = 32'h100;
    bus.if_req     = 1'b1;
    bus.if_addr    = 32'h1F;
    exp_load_q.push_back(model_load(W, 32'h100));
    exp_fetch_q.push_back(model_load(W, 32'h1F));
    @(posedge clk); #1 bus.lsb_oprand = 32'd0;
    wait_pulse(1'b0, c);
    check("priority load latency", c, 5);
    @(posedge clk); #1 bus.if_req = 1'b0;
    wait_pulse(1'b1, c);
    check("deferred fetch latency", c, 5);

    // Flush two cycles into a LW, then a normal LB.
    issue_lsb(1'b0, W, 32'h100, 32'd0, 1'b0);
    @(posedge clk); #1 bus.flush = 1'b1;
    @(posedge clk); #1 bus.flush = 1'b0;
    @(negedge clk); check("flush to idle", {30'd0, bus.ready}, 32'd1);
    repeat (6) @(negedge clk);
    load_and_time(B, 32'h10, "LB after flush");

    // Flush during SW does not stop its writes.
    issue_lsb(1'b1, W, 32'h600, 32'hDEAD_BEEF, 1'b0);
    @(posedge clk); #1 bus.flush = 1'b1;
    @(posedge clk); #1 bus.flush = 1'b0;
    @(negedge clk); check("SW flush busy3", {31'd0, bus.ready[0]}, 32'd0);
    @(negedge clk); check("SW flush busy4", {31'd0, bus.ready[0]}, 32'd0);
    @(negedge clk); check("SW flush idle5", {31'd0, bus.ready[0]}, 32'd1);
    load_and_time(W, 32'h600, "LW readback latency");

    // rdy low for two cycles in the middle of a LW.
    issue_lsb(1'b0, W, 32'h100, 32'd0, 1'b1);
    @(posedge clk); #1 bus.rdy = 1'b0;
    @(negedge clk); check("freeze mem_a", bus.mem_a, 32'h101);
    check("freeze mem_wr", {31'd0, bus.mem_wr}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk); check("freeze mem_a hold", bus.mem_a, 32'h101);
    @(posedge clk); #1 bus.rdy = 1'b1;
    wait_pulse(1'b0, c);
    check("freeze latency", c, 4);

    // Address wrap across 2^32.
    preload(32'hFFFF_FFFE, 8'hA1); preload(32'hFFFF_FFFF, 8'hB2);
    preload(32'h0000_0000, 8'hC3); preload(32'h0000_0001, 8'hD4);
    load_and_time(W, 32'hFFFF_FFFE, "wrap LW latency");

    // Reset in the middle of a SW: only the first byte lands.
    wait_idle();
    bus.lsb_oprand = 32'h0010_0020 | (32'(W) << 12);
    bus.lsb_addr   = 32'h700;
    bus.lsb_wdata  = 32'h1122_3344;
    exp_wr_q.push_back('{a: 32'h700, d: 8'h44});
    mdl[32'h700] = 8'h44;
    @(posedge clk); #1 bus.lsb_oprand = 32'd0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid reset ready", {30'd0, bus.ready}, 32'd1);
    check("mid reset mem_wr", {31'd0, bus.mem_wr}, 32'd0);
    load_and_time(W, 32'h700, "post reset LW latency");

    // Randomized traffic over overlapping small regions, incl. the I/O window.
    for (int it = 0; it < 60; it++) begin
      logic [31:0] a;
      logic [2:0]  f3;
      int          kind;
      case ($urandom_range(0, 3))
        0:       a = 32'h1000 + 32'($urandom_range(0, 31));
        1:       a = 32'h0003_0000 + 32'($urandom_range(0, 15));
        2:       a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        default: a = 32'h2000 + 32'($urandom_range(0, 15));
      endcase
      kind = $urandom_range(0, 3);
      if (kind == 0) begin
        case ($urandom_range(0, 4))
          0: f3 = B; 1: f3 = H; 2: f3 = W; 3: f3 = BU; default: f3 = HU;
        endcase
        load_and_time(f3, a, "random load latency");
      end else if (kind == 1) begin
        f3 = 3'($urandom_range(0, 2));
        issue_lsb(1'b1, f3, a, $urandom, 1'b0);
        store_run(1'b1);
      end else if (kind == 2) begin
        fetch_and_time(a);
      end else begin
        int d;
        f3 = 3'($urandom_range(0, 2));
        d  = $urandom_range(1, n_of(f3) + 1);
        issue_lsb(1'b0, f3, a, 32'd0, 1'b0);
        repeat (d - 1) begin @(posedge clk); #1; end
        bus.flush = 1'b1;
        @(posedge clk); #1 bus.flush = 1'b0;
        @(negedge clk); check("random flush idle", {30'd0, bus.ready}, 32'd1);
      end
    end

    repeat (4) @(negedge clk);
    check("load queue drained",  32'(exp_load_q.size()),  32'd0);
    check("fetch queue drained", 32'(exp_fetch_q.size()), 32'd0);
    check("write queue drained", 32'(exp_wr_q.size()),    32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
